// File: rtl/main_mem_arbiter.sv
// Purpose : arbitrates the single 128-bit main memory between icache (read) and dcache (read/write).
// Latency : request -> memory strobe next cycle; busy release one cycle after memory completes (>= 3 cycles).
// Backpres: losing/late requester keeps its *_BUSY_WAIT high until its own transaction completes.
//
// Ports:
//   clock, reset                  system clock, asynchronous active-low reset
//   I_READ/I_ADDRESS              icache line read request
//   I_READ_DATA/I_BUSY_WAIT       line returned to icache, icache stall
//   D_READ/D_WRITE/D_ADDRESS      dcache line read / write-back request
//   D_WRITE_DATA                  dcache write-back line
//   D_READ_DATA/D_BUSY_WAIT       line returned to dcache, dcache stall
//   MEM_READ/MEM_WRITE            main memory strobes (registered, held for the whole grant)
//   MEM_ADDRESS/MEM_WRITE_DATA    main memory line address / write line
//   MEM_READ_DATA/MEM_BUSY_WAIT   main memory read line / busy
//
// Build option: define ARB_ROUND_ROBIN_EN to break simultaneous requests in
// favour of the port that did not win last; otherwise the dcache always wins ties.
module main_mem_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_READ,
  input  logic [ADDR_WIDTH-1:0] I_ADDRESS,
  output logic [DATA_WIDTH-1:0] I_READ_DATA,
  output logic                  I_BUSY_WAIT,
  input  logic                  D_READ,
  input  logic                  D_WRITE,
  input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
  input  logic [DATA_WIDTH-1:0] D_WRITE_DATA,
  output logic [DATA_WIDTH-1:0] D_READ_DATA,
  output logic                  D_BUSY_WAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
  output logic [DATA_WIDTH-1:0] MEM_WRITE_DATA,
  input  logic [DATA_WIDTH-1:0] MEM_READ_DATA,
  input  logic                  MEM_BUSY_WAIT
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_I = 3'd1,
    GRANT_D = 3'd2,
    DONE_I  = 3'd3,
    DONE_D  = 3'd4
  } state_t;

  state_t state;
  logic   seen_busy;   // memory has shown busy at least once during this grant
`ifdef ARB_ROUND_ROBIN_EN
  logic   last_grant;  // 0 = icache won last, 1 = dcache won last
`endif

  logic i_req;
  logic d_req;
  logic pick_d;
  logic mem_done;

  assign i_req = I_READ;
  assign d_req = D_READ | D_WRITE;

  // A grant finishes on the first edge where busy is low after having been
  // seen high, so memories that raise busy a cycle late are still handled.
  assign mem_done = seen_busy & ~MEM_BUSY_WAIT;

  // Stalls are released only during the one-cycle DONE state of that port;
  // gated by reset so both stalls read low while the block is held in reset.
  assign I_BUSY_WAIT = reset & i_req & (state != DONE_I);
  assign D_BUSY_WAIT = reset & d_req & (state != DONE_D);

  // Tie-break between simultaneous requests sampled in IDLE.
  always_comb begin
    pick_d = 1'b0;
    if (d_req && !i_req) begin
      pick_d = 1'b1;
    end else if (d_req && i_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick_d = ~last_grant;
`else
      pick_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      seen_busy      <= 1'b0;
      MEM_READ       <= 1'b0;
      MEM_WRITE      <= 1'b0;
      MEM_ADDRESS    <= '0;
      MEM_WRITE_DATA <= '0;
      I_READ_DATA    <= '0;
      D_READ_DATA    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // MEM_BUSY_WAIT is deliberately ignored here.
          seen_busy <= 1'b0;
          if (i_req || d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= pick_d;
`endif
            if (pick_d) begin
              state          <= GRANT_D;
              MEM_ADDRESS    <= D_ADDRESS;
              MEM_WRITE_DATA <= D_WRITE_DATA;
              // A combined read+write request is issued as a write only.
              MEM_WRITE      <= D_WRITE;
              MEM_READ       <= D_READ & ~D_WRITE;
            end else begin
              state          <= GRANT_I;
              MEM_ADDRESS    <= I_ADDRESS;
              MEM_WRITE      <= 1'b0;
              MEM_READ       <= 1'b1;
            end
          end
        end

        GRANT_I: begin
          if (MEM_BUSY_WAIT) begin
            seen_busy <= 1'b1;
          end else if (mem_done) begin
            seen_busy <= 1'b0;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            // If the icache gave up mid-grant the line is dropped and
            // the port gets no DONE cycle.
            if (i_req) begin
              I_READ_DATA <= MEM_READ_DATA;
              state       <= DONE_I;
            end else begin
              state       <= IDLE;
            end
          end
        end

        GRANT_D: begin
          if (MEM_BUSY_WAIT) begin
            seen_busy <= 1'b1;
          end else if (mem_done) begin
            seen_busy <= 1'b0;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            if (d_req) begin
              // Write-backs leave the last returned line untouched.
              if (MEM_READ) begin
                D_READ_DATA <= MEM_READ_DATA;
              end
              state <= DONE_D;
            end else begin
              state <= IDLE;
            end
          end
        end

        // One release cycle; a request still high afterwards is a new one.
        DONE_I:  state <= IDLE;
        DONE_D:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Purpose : scoreboard bench for main_mem_arbiter with a behavioural memory and reference line store.
// Latency : memory busy length and late-busy start are configurable/randomised per transaction.
// Backpres: icache/dcache agents hold requests until their busy drops, monitor checks each release.
module tb_main_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          I_READ = 1'b0;
  logic [AW-1:0] I_ADDRESS = '0;
  logic [DW-1:0] I_READ_DATA;
  logic          I_BUSY_WAIT;
  logic          D_READ = 1'b0;
  logic          D_WRITE = 1'b0;
  logic [AW-1:0] D_ADDRESS = '0;
  logic [DW-1:0] D_WRITE_DATA = '0;
  logic [DW-1:0] D_READ_DATA;
  logic          D_BUSY_WAIT;
  logic          MEM_READ;
  logic          MEM_WRITE;
  logic [AW-1:0] MEM_ADDRESS;
  logic [DW-1:0] MEM_WRITE_DATA;
  logic [DW-1:0] MEM_READ_DATA;
  logic          MEM_BUSY_WAIT;

  always #5 clock = ~clock;

  main_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READ_DATA(I_READ_DATA), .I_BUSY_WAIT(I_BUSY_WAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITE_DATA(D_WRITE_DATA),
    .D_READ_DATA(D_READ_DATA), .D_BUSY_WAIT(D_BUSY_WAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITE_DATA(MEM_WRITE_DATA), .MEM_READ_DATA(MEM_READ_DATA), .MEM_BUSY_WAIT(MEM_BUSY_WAIT)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, DW'(act), DW'(exp));
  endtask

  // ---------------- reference model state ----------------
  // icache uses line addresses 0x00-0x7F (never written), dcache 0x80-0xFF.
  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } mop_t;

  mop_t          mq_i[$];
  mop_t          mq_d[$];
  logic [DW-1:0] iq[$];
  logic [DW-1:0] dq[$];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] i_last = '0;
  logic [DW-1:0] d_last = '0;
  bit            grant_log[$];

  // ---------------- behavioural main memory ----------------
  logic [DW-1:0] mem [256];
  logic          strobe;
  int            cnt = 0;
  int            cur_n = 1;
  int            cur_late = 0;
  int            cfg_n = 3;
  int            cfg_late = 0;
  bit            run_rand_mem = 1'b0;

  assign strobe        = MEM_READ | MEM_WRITE;
  assign MEM_BUSY_WAIT = strobe && (cnt >= cur_late) && (cnt < cur_late + cur_n);
  assign MEM_READ_DATA = mem[MEM_ADDRESS[7:0]];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt      <= 0;
      cur_n    <= 1;
      cur_late <= 0;
    end else begin
      cnt <= strobe ? cnt + 1 : 0;
      if (MEM_WRITE && cnt == 0) mem[MEM_ADDRESS[7:0]] <= MEM_WRITE_DATA;
      if (!strobe) begin
        cur_n    <= run_rand_mem ? int'($urandom_range(1, 4)) : cfg_n;
        cur_late <= run_rand_mem ? int'($urandom_range(0, 1)) : cfg_late;
      end
    end
  end

  // ---------------- monitor ----------------
  logic          prev_strobe = 1'b0;
  logic [AW-1:0] held_a = '0;
  logic [1:0]    held_op = '0;
  mop_t          mon_e;

  always @(negedge clock) begin
    if (reset) begin
      if (I_READ && !I_BUSY_WAIT) begin
        if (iq.size() == 0) chk("i_unexpected_release", DW'(1), DW'(0));
        else chk("i_read_data", I_READ_DATA, iq.pop_front());
      end
      if ((D_READ || D_WRITE) && !D_BUSY_WAIT) begin
        if (dq.size() == 0) chk("d_unexpected_release", DW'(1), DW'(0));
        else chk("d_read_data", D_READ_DATA, dq.pop_front());
      end
      if (strobe && !prev_strobe) begin
        if (MEM_ADDRESS[7] ? (mq_d.size() == 0) : (mq_i.size() == 0)) begin
          chk("mem_unexpected_strobe", DW'(1), DW'(0));
        end else begin
          if (MEM_ADDRESS[7]) mon_e = mq_d.pop_front();
          else                mon_e = mq_i.pop_front();
          chk("mem_addr", DW'(MEM_ADDRESS), DW'(mon_e.a));
          chk1("mem_read", MEM_READ, mon_e.rd);
          chk1("mem_write", MEM_WRITE, mon_e.wr);
          if (mon_e.wr) chk("mem_wdata", MEM_WRITE_DATA, mon_e.d);
          grant_log.push_back(MEM_ADDRESS[7]);
        end
        held_a  <= MEM_ADDRESS;
        held_op <= {MEM_READ, MEM_WRITE};
      end else if (strobe) begin
        chk("mem_addr_stable", DW'(MEM_ADDRESS), DW'(held_a));
        chk("mem_op_stable", DW'({MEM_READ, MEM_WRITE}), DW'(held_op));
      end
    end
    prev_strobe <= strobe;
  end

  // ---------------- agents ----------------
  task automatic i_req(input logic [AW-1:0] a, input bit keep, output int scyc);
    bit done;
    done = 1'b0;
    scyc = 0;
    i_last = ref_mem[a[7:0]];
    iq.push_back(i_last);
    mq_i.push_back('{rd: 1'b1, wr: 1'b0, a: a, d: '0});
    I_ADDRESS = a;
    I_READ    = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock); #1;
      if (MEM_READ && !MEM_ADDRESS[7]) scyc++;
      if (!I_BUSY_WAIT) done = 1'b1;
    end
    if (!done) chk("i_timeout", DW'(0), DW'(1));
    if (!keep) I_READ = 1'b0;
  endtask

  task automatic d_req(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input bit keep);
    bit done;
    done = 1'b0;
    if (wr) ref_mem[a[7:0]] = wd;
    else    d_last = ref_mem[a[7:0]];
    dq.push_back(d_last);
    mq_d.push_back('{rd: rd & ~wr, wr: wr, a: a, d: wd});
    D_ADDRESS    = a;
    D_WRITE_DATA = wd;
    D_READ       = rd;
    D_WRITE      = wr;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock); #1;
      if (!D_BUSY_WAIT) done = 1'b1;
    end
    if (!done) chk("d_timeout", DW'(0), DW'(1));
    if (!keep) begin
      D_READ  = 1'b0;
      D_WRITE = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int            s1, s2, scyc;
  bit            seen;
  bit            exp_order[4];
  logic [DW-1:0] v;
  logic [AW-1:0] ra;
  int            op;

  initial begin
    for (int k = 0; k < 256; k++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      mem[k]     <= v;
      ref_mem[k]  = v;
    end
    mem[8'h12]     <= {16{8'hA5}};
    ref_mem[8'h12]  = {16{8'hA5}};

    // Reset state, with both requests raised to prove stalls are gated.
    #3;
    I_READ = 1'b1;
    D_READ = 1'b1;
    #10;
    chk1("rst_mem_read", MEM_READ, 1'b0);
    chk1("rst_mem_write", MEM_WRITE, 1'b0);
    chk1("rst_i_busy", I_BUSY_WAIT, 1'b0);
    chk1("rst_d_busy", D_BUSY_WAIT, 1'b0);
    chk("rst_mem_addr", DW'(MEM_ADDRESS), DW'(0));
    chk("rst_mem_wdata", MEM_WRITE_DATA, DW'(0));
    chk("rst_i_data", I_READ_DATA, DW'(0));
    chk("rst_d_data", D_READ_DATA, DW'(0));
    I_READ = 1'b0;
    D_READ = 1'b0;
    @(negedge clock); #1;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;

    // Reset asserted in the middle of a dcache write-back.
    cfg_n = 4; cfg_late = 0;
    mq_d.push_back('{rd: 1'b0, wr: 1'b1, a: 28'h00000F0, d: 128'h1234});
    D_ADDRESS = 28'h00000F0; D_WRITE_DATA = 128'h1234; D_WRITE = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock); #1;
      if (MEM_WRITE) seen = 1'b1;
    end
    chk1("t1_write_started", seen, 1'b1);
    @(negedge clock); #1;
    I_READ = 1'b1;
    reset  = 1'b0;
    #1;
    chk1("t1_mem_write", MEM_WRITE, 1'b0);
    chk1("t1_mem_read", MEM_READ, 1'b0);
    chk1("t1_d_busy", D_BUSY_WAIT, 1'b0);
    chk1("t1_i_busy", I_BUSY_WAIT, 1'b0);
    D_WRITE = 1'b0;
    I_READ  = 1'b0;
    i_last  = '0;
    d_last  = '0;
    @(negedge clock); #1;
    reset = 1'b1;
    @(negedge clock); #1;

    // icache read, 5 busy cycles -> strobe for 6, one-cycle release.
    cfg_n = 5;
    i_req(28'h0000012, 1'b1, scyc);
    chk("t2_strobe_cycles", DW'(scyc), DW'(6));
    chk("t2_data", I_READ_DATA, {16{8'hA5}});
    @(negedge clock); #1;
    chk1("t2_busy_one_cycle", I_BUSY_WAIT, 1'b1);
    I_READ = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk1("t2_no_regrant", MEM_READ, 1'b0);

    // dcache write-back: write strobe only, returned line untouched.
    cfg_n = 3;
    d_req(1'b0, 1'b1, 28'h00000FF, 128'hDEAD_BEEF, 1'b0);
    chk("t5_d_data_unchanged", D_READ_DATA, d_last);
    repeat (2) @(negedge clock);
    #1;

    // icache abandons its read mid-grant.
    cfg_n = 4;
    mq_i.push_back('{rd: 1'b1, wr: 1'b0, a: 28'h0000020, d: '0});
    I_ADDRESS = 28'h0000020; I_READ = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock); #1;
      if (MEM_READ) seen = 1'b1;
    end
    chk1("t6_read_started", seen, 1'b1);
    scyc = 1;
    repeat (2) begin
      @(negedge clock); #1;
      if (MEM_READ) scyc++;
    end
    I_READ = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clock); #1;
      if (MEM_READ) scyc++;
      else seen = 1'b1;
    end
    chk("t6_strobe_cycles", DW'(scyc), DW'(5));
    chk("t6_data_unchanged", I_READ_DATA, i_last);
    repeat (3) @(negedge clock);
    #1;
    chk1("t6_no_regrant", MEM_READ, 1'b0);

    // Continuous contention: each port asks twice, re-requesting immediately.
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif
    cfg_n = 2;
    grant_log.delete();
    fork
      begin
        i_req(28'h0000030, 1'b1, s1);
        i_req(28'h0000031, 1'b0, s1);
      end
      begin
        d_req(1'b1, 1'b0, 28'h0000090, '0, 1'b1);
        d_req(1'b1, 1'b0, 28'h0000091, '0, 1'b0);
      end
    join
    chk("tie_grant_count", DW'(grant_log.size()), DW'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < grant_log.size()) chk1("tie_grant_order", grant_log[k], exp_order[k]);
    end
    repeat (2) @(negedge clock);
    #1;

    // Randomised concurrent traffic with random memory timing.
    run_rand_mem = 1'b1;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clock);
          #1;
          i_req(AW'($urandom_range(0, 127)), 1'b0, s2);
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clock);
          #1;
          op = int'($urandom_range(0, 2));
          ra = AW'(32'h80 + $urandom_range(0, 111));
          d_req(op != 1, op != 0, ra, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end
      end
    join

    repeat (10) @(negedge clock);
    chk("iq_drained", DW'(iq.size()), DW'(0));
    chk("dq_drained", DW'(dq.size()), DW'(0));
    chk("mq_i_drained", DW'(mq_i.size()), DW'(0));
    chk("mq_d_drained", DW'(mq_d.size()), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
